pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the datapath and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-005 The block SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-006 The block SHALL have port imem_addr, output, WIDTH, the fetch address, equal to pc.
REQ-007 The block SHALL have port imem_ready, input, 1, asserted by memory when imem_rdata is valid.
REQ-008 The block SHALL have port imem_rdata, input, WIDTH, the fetched instruction word.
REQ-009 The block SHALL have port instruction, output, WIDTH, the held instruction presented to control_signal and decode.
REQ-010 The block SHALL have port instruction_valid, output, 1, high while instruction is valid for execution.
REQ-011 The block SHALL have port advance, input, 1, the core's request to retire the current instruction and update pc.
REQ-012 The block SHALL have port mux_pc_signal, input, 1, selecting pc+imm (taken branch or jal) from control_signal.
REQ-013 The block SHALL have port mux_jalr, input, 1, selecting rs1_data+imm (jalr) from control_signal.
REQ-014 The block SHALL have port imm, input, WIDTH, the sign-extended immediate.
REQ-015 The block SHALL have port rs1_data, input, WIDTH, the jalr base register value.
REQ-016 The block SHALL have port pc, output, WIDTH, the address of the current instruction.
REQ-017 The block SHALL have port pc_plus4, output, WIDTH, equal to pc+4 combinationally, for jal/jalr writeback.
REQ-018 The block SHALL have port misaligned_fault, output, 1, a sticky flag for a misaligned target.

Function
REQ-019 The FSM SHALL have states FETCH, HOLD and HALT.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_ready is sampled high.
REQ-021 In FETCH with imem_ready=1, the block SHALL latch imem_rdata into instruction and move to HOLD; instruction_valid SHALL then be 1 from the next cycle.
REQ-022 In HOLD, imem_req SHALL be 0, and instruction and pc SHALL be held constant until advance=1.
REQ-023 In HOLD with advance=1, on that edge pc SHALL load next_pc, instruction_valid SHALL drop to 0 and the FSM SHALL move to FETCH.
REQ-024 next_pc priority SHALL be: mux_jalr=1 -> (rs1_data+imm) with bit0 cleared; else mux_pc_signal=1 -> pc+imm; else pc+4.
REQ-025 mux_pc_signal, mux_jalr, imm and rs1_data SHALL be sampled only on the HOLD-and-advance edge; advance SHALL be ignored in FETCH and HALT.
REQ-026 All additions SHALL be modulo 2^WIDTH; wrap from 32'hFFFF_FFFC to 0 SHALL be silent.
REQ-027 The minimum cycle per instruction SHALL be 2 (FETCH with immediate ready, then HOLD with immediate advance).
REQ-028 HALT SHALL be terminal until rst, with imem_req=0 and instruction_valid=0.

Reset
REQ-029 On a rising edge with rst=1, pc SHALL be set to RESET_PC, the state to FETCH, instruction to 32'h0000_0013 (NOP), instruction_valid to 0 and misaligned_fault to 0.
REQ-030 A reset mid-fetch SHALL abandon the outstanding request, and a subsequent imem_ready SHALL be ignored until the FSM re-enters FETCH.
REQ-031 rst SHALL take priority over advance and imem_ready on the same edge.

Configuration
REQ-032 With macro PC_MISALIGN_CHECK_EN defined, an advance whose next_pc[1:0]!=0 SHALL leave pc unchanged, set misaligned_fault to 1 and enter HALT.
REQ-033 Without PC_MISALIGN_CHECK_EN, next_pc[1:0] SHALL be forced to 2'b00, misaligned_fault SHALL be tied to 0, and HALT SHALL be unreachable.

Verification
REQ-034 Reset, then imem_ready=1 with rdata 32'h0062_8233 -> pc=0, instruction=32'h0062_8233, and instruction_valid=1 one cycle later.
REQ-035 HOLD, advance=1 with no selects -> pc=4, imem_req=1; hold imem_ready=0 for 3 cycles -> imem_addr stays 4 and instruction_valid stays 0.
REQ-036 pc=8, advance with mux_pc_signal=1 and imm=16 -> pc=24; a second case with mux_pc_signal=1, mux_jalr=1, rs1_data=0x101 and imm=3 -> pc=0x104.
REQ-037 pc=32'hFFFF_FFFC, advance with no selects -> pc=0 and no fault.
REQ-038 With PC_MISALIGN_CHECK_EN, advance with mux_pc_signal=1 and imm=2 from pc=0 -> misaligned_fault=1, HALT, pc=0; rst=1 then clears the fault and pc=RESET_PC.
REQ-039 rst asserted during FETCH while imem_ready=1 -> instruction=NOP, instruction_valid=0 and pc=RESET_PC after that edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests instruction words and holds each one until the core retires it.
// Optional macro PC_MISALIGN_CHECK_EN traps misaligned targets into a sticky fault and a terminal HALT state.

module pc_fetch_unit #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instruction,
    output logic             instruction_valid,
    input  logic             advance,
    input  logic             mux_pc_signal,
    input  logic             mux_jalr,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned_fault
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] NOP_WORD   = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(32'd4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(32'd3);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] instr_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             fault_r;
    logic             fault_nxt_s;
    logic             req_r;
    logic             req_nxt_s;
    logic [WIDTH-1:0] jalr_sum_s;
    logic [WIDTH-1:0] next_pc_raw_s;
    logic [WIDTH-1:0] next_pc_s;
    logic             misaligned_s;

    // Branch target selection; jalr wins over pc-relative, all sums wrap modulo 2^WIDTH.
    always_comb begin
        jalr_sum_s = rs1_data + imm;
        if (mux_jalr) begin
            next_pc_raw_s = {jalr_sum_s[WIDTH-1:1], 1'b0};
        end else if (mux_pc_signal) begin
            next_pc_raw_s = pc_r + imm;
        end else begin
            next_pc_raw_s = pc_r + FOUR;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Misaligned targets are reported rather than silently rounded.
    always_comb begin
        next_pc_s    = next_pc_raw_s;
        misaligned_s = |next_pc_raw_s[1:0];
    end
`else
    // Without the check the target is forced word-aligned and HALT is never entered.
    always_comb begin
        next_pc_s    = next_pc_raw_s & ALIGN_MASK;
        misaligned_s = 1'b0;
    end
`endif

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        fault_nxt_s = fault_r;
        case (state_r)
            FETCH: begin
                if (imem_ready) begin
                    instr_nxt_s = imem_rdata;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (advance) begin
                    valid_nxt_s = 1'b0;
                    if (misaligned_s) begin
                        fault_nxt_s = 1'b1;
                        state_nxt_s = HALT;
                    end else begin
                        pc_nxt_s    = next_pc_s;
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HALT: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = HALT;
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = FETCH;
            end
        endcase
        req_nxt_s = (state_nxt_s == FETCH);
    end

    // State and output registers; reset overrides advance and imem_ready on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            req_r   <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            valid_r <= valid_nxt_s;
            fault_r <= fault_nxt_s;
            req_r   <= req_nxt_s;
        end
    end

    assign imem_req          = req_r;
    assign imem_addr         = pc_r;
    assign pc                = pc_r;
    assign pc_plus4          = pc_r + FOUR;
    assign instruction       = instr_r;
    assign instruction_valid = valid_r;
    assign misaligned_fault  = fault_r;

    pc_fetch_unit_checker #(.WIDTH(WIDTH)) u_checker (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .instruction_valid (instruction_valid),
        .advance           (advance),
        .pc                (pc),
        .instruction       (instruction),
        .misaligned_fault  (misaligned_fault)
    );

endmodule

// Protocol invariants of the fetch unit, kept apart from the datapath.
module pc_fetch_unit_checker #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             imem_req,
    input logic             instruction_valid,
    input logic             advance,
    input logic [WIDTH-1:0] pc,
    input logic [WIDTH-1:0] instruction,
    input logic             misaligned_fault
);

    a_req_valid_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(imem_req && instruction_valid));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (instruction_valid && !advance) |=> ($stable(pc) && $stable(instruction)));

`ifndef PC_MISALIGN_CHECK_EN
    a_no_fault: assert property (@(posedge clk) disable iff (rst) !misaligned_fault);
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: stimulus pushes expected {pc, instruction} into a scoreboard,
// a monitor pops and compares whenever instruction_valid rises.

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        advance;
    logic        mux_pc_signal;
    logic        mux_jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .advance           (advance),
        .mux_pc_signal     (mux_pc_signal),
        .mux_jalr          (mux_jalr),
        .imm               (imm),
        .rs1_data          (rs1_data),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .misaligned_fault  (misaligned_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising instruction_valid is one presented instruction.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (instruction_valid === 1'b1 && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_instr", instruction, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", pc, e.pc);
                    chk("sb_instr", instruction, e.instr);
                end
            end
            prev_valid = (instruction_valid === 1'b1);
        end
    end

    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fetch_req_seen", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        sb_q.push_back('{pc: exp_pc, instr: word});
        imem_rdata = word;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("hold_req_low", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic do_adv(input logic jalr, input logic br, input logic [31:0] i, input logic [31:0] rs1);
        mux_jalr      = jalr;
        mux_pc_signal = br;
        imm           = i;
        rs1_data      = rs1;
        advance       = 1'b1;
        @(posedge clk); #1;
        advance       = 1'b0;
        mux_jalr      = 1'b1;
        mux_pc_signal = 1'b1;
        imm           = $urandom;
        rs1_data      = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
        mux_pc_signal = 1'b0; mux_jalr = 1'b0; imm = 32'h0; rs1_data = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_valid", {31'b0, instruction_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd1);
        chk("rst_fault", {31'b0, misaligned_fault}, 32'd0);

        do_fetch(32'h0, 32'h0062_8233);
        do_adv(1'b0, 1'b0, 32'h0, 32'h0);
        chk("seq_pc4", pc, 32'h4);
        chk("seq_req", {31'b0, imem_req}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("wait_addr", imem_addr, 32'h4);
            chk("wait_valid", {31'b0, instruction_valid}, 32'd0);
        end

        do_fetch(32'h4, 32'h0010_0093);
        do_adv(1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(32'h8, 32'h0020_0113);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_pc", pc, 32'h8);
        chk("hold_instr", instruction, 32'h0020_0113);
        do_adv(1'b0, 1'b1, 32'd16, 32'h0);
        chk("branch_pc", pc, 32'd24);
        do_fetch(32'd24, 32'h0000_006F);
        do_adv(1'b1, 1'b1, 32'd3, 32'h0000_0101);
        chk("jalr_pc", pc, 32'h0000_0104);

        // advance in FETCH must be ignored
        advance = 1'b1; mux_pc_signal = 1'b1; imm = 32'h40;
        @(posedge clk); #1;
        advance = 1'b0;
        chk("fetch_adv_ignored", pc, 32'h0000_0104);

        // reset beats a simultaneous imem_ready
        imem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        chk("rstf_instr", instruction, 32'h0000_0013);
        chk("rstf_valid", {31'b0, instruction_valid}, 32'd0);
        chk("rstf_pc", pc, 32'h0);

        do_fetch(32'h0, 32'h0030_0193);
        do_adv(1'b1, 1'b0, 32'h0000_000D, 32'hFFFF_FFF0);
        chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0073);
        do_adv(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_fault", {31'b0, misaligned_fault}, 32'd0);

        do_fetch(32'h0, 32'h0020_8133);
        do_adv(1'b0, 1'b1, 32'd2, 32'h0);
`ifdef PC_MISALIGN_CHECK_EN
        chk("mis_fault", {31'b0, misaligned_fault}, 32'd1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        imem_ready = 1'b1; advance = 1'b1;
        repeat (2) @(posedge clk);
        #1 imem_ready = 1'b0; advance = 1'b0;
        chk("halt_valid", {31'b0, instruction_valid}, 32'd0);
        chk("halt_pc", pc, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mis_clr_fault", {31'b0, misaligned_fault}, 32'd0);
        chk("mis_clr_pc", pc, 32'h0);
`else
        chk("align_pc", pc, 32'h0);
        chk("align_fault", {31'b0, misaligned_fault}, 32'd0);
        chk("align_req", {31'b0, imem_req}, 32'd1);
`endif
        do_fetch(32'h0, 32'h4000_0033);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
